unified_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the instruction-fetch port and the load/store data port of the 16-bit MIPS core.
- Used when instruction and data storage are merged into one RAM.
- Arbitrates requests, sequences one memory access at a time and returns read data or a write acknowledgement to the winning requester.
- Data port has priority; a streak limit keeps fetch from starving.

---
 rtl/unified_mem_arbiter_pkg.sv | 14 +
 rtl/mem_arb_select.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 117 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection with data priority, plus the streak counter that bounds
// consecutive data grants while fetch waits.
module mem_arb_select
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic winner,
  output logic streak_at_limit
);

  logic [STREAK_W-1:0] streak;

  assign streak_at_limit = (streak == STREAK_W'(MAX_STREAK));
  assign winner = (d_req && !(if_req && streak_at_limit)) ? OWN_D : OWN_IF;

  // Only a data grant taken over a waiting fetch extends the streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant) begin
      if (winner == OWN_D && if_req) streak <= streak + STREAK_W'(1);
      else                           streak <= '0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by fetch and load/store ports; one access in flight,
// grant in IDLE, response MEM_LAT+1 cycles after grant.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state;
  logic [2:0]        lat_cnt;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] resp_data;
  logic              grant;
  logic              winner;
  logic              sel_unused;

  assign grant = (state == IDLE) && (if_req || d_req);

  mem_arb_select #(.MAX_STREAK(MAX_STREAK)) u_sel (
    .clk             (clk),
    .reset           (reset),
    .if_req          (if_req),
    .d_req           (d_req),
    .grant           (grant),
    .winner          (winner),
    .streak_at_limit (sel_unused)
  );

  assign if_gnt = grant && (winner == OWN_IF);
  assign d_gnt  = grant && (winner == OWN_D);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= OWN_IF;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state     <= ISSUE;
            owner     <= winner;
            lat_we    <= (winner == OWN_D) && d_we;
            lat_addr  <= (winner == OWN_D) ? d_addr : if_addr;
            lat_wdata <= (winner == OWN_D) ? d_wdata : '0;
          end
        end
        ISSUE: begin
          lat_cnt <= 3'(MEM_LAT - 1);
          state   <= (MEM_LAT == 1) ? RESP : WAIT;
        end
        // Leave WAIT as the counter steps down to zero so RESP lines up with mem_rdata.
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = mem_en ? lat_addr  : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;
  assign busy      = (state != IDLE);

  assign resp_data = lat_we ? '0 : mem_rdata;
  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign d_rvalid  = (state == RESP) && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? resp_data : if_rdata_q;
  assign d_rdata   = d_rvalid  ? resp_data : d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= resp_data;
      if (d_rvalid)  d_rdata_q  <= resp_data;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a MEM_LAT=1 instance with a behavioural
// RAM driven from a cycle table, and a MEM_LAT=3 instance for the latency check.
module tb_unified_mem_arbiter;

  logic clk;
  logic reset;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        l3_if_req;
  logic [15:0] l3_if_addr;
  logic        l3_d_req, l3_d_we;
  logic [15:0] l3_d_addr, l3_d_wdata;
  logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_mem_en, l3_mem_we, l3_busy;
  logic [15:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  int tests = 0;
  int fails = 0;

  unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_STREAK(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .MAX_STREAK(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_rvalid(l3_if_rvalid),
    .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read, read-before-write; preloaded while reset is low.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (!reset) begin
      mem[16'h0010] <= 16'hA5C3;
      mem[16'h0100] <= 16'hDEAD;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // Three-cycle memory returning the inverted address.
  logic [15:0] l3_p0, l3_p1;
  always @(posedge clk) begin
    if (l3_mem_en) l3_p0 <= ~l3_mem_addr;
    l3_p1        <= l3_p0;
    l3_mem_rdata <= l3_p1;
  end

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [15:0] e_mem_addr;
    logic [15:0] e_mem_wdata;
    logic        e_if_rv;
    logic        e_d_rv;
    logic [15:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                              input logic [15:0] da, input logic [15:0] dd,
                              input logic eig, input logic edg, input logic emen, input logic emwe,
                              input logic [15:0] ema, input logic [15:0] emwd,
                              input logic eirv, input logic edrv, input logic [15:0] erd,
                              input logic eb);
    vec_t v;
    v.if_req = ir;    v.if_addr = ia;  v.d_req = dr;       v.d_we = dw;
    v.d_addr = da;    v.d_wdata = dd;  v.e_if_gnt = eig;   v.e_d_gnt = edg;
    v.e_mem_en = emen; v.e_mem_we = emwe; v.e_mem_addr = ema; v.e_mem_wdata = emwd;
    v.e_if_rv = eirv; v.e_d_rv = edrv; v.e_rdata = erd;    v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int          grants_seen;
  logic        grant_order [$];
  logic        exp_order [10];
  int          men_count;
  int          rv_cycle;

  initial begin
    reset = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    l3_if_req = 0; l3_if_addr = 0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = 0; l3_d_wdata = 0;

    // Cycle table: fetch read, data write then read-back, simultaneous requests.
    vecs[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5C3, 1);
    vecs[3]  = mk(0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0100, 16'h1234, 0, 0, 16'h0000, 1);
    vecs[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[7]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1);
    vecs[9]  = mk(1, 16'h0010, 1, 0, 16'h0100, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[10] = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[11] = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1);
    vecs[12] = mk(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
    vecs[13] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1);
    vecs[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5C3, 1);
    vecs[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);

    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    #2;
    check("reset busy",     busy, 0);
    check("reset mem_en",   {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("reset rvalid",   {if_rvalid, d_rvalid}, 0);
    check("reset rdata",    {if_rdata, d_rdata}, 0);
    check("reset l3 busy",  {l3_busy, l3_mem_en, l3_if_rvalid}, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req;   d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      @(negedge clk);
      check($sformatf("row%0d if_gnt", i),    if_gnt,    vecs[i].e_if_gnt);
      check($sformatf("row%0d d_gnt", i),     d_gnt,     vecs[i].e_d_gnt);
      check($sformatf("row%0d mem_en", i),    mem_en,    vecs[i].e_mem_en);
      check($sformatf("row%0d mem_we", i),    mem_we,    vecs[i].e_mem_we);
      check($sformatf("row%0d mem_addr", i),  mem_addr,  vecs[i].e_mem_addr);
      check($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      check($sformatf("row%0d if_rvalid", i), if_rvalid, vecs[i].e_if_rv);
      check($sformatf("row%0d d_rvalid", i),  d_rvalid,  vecs[i].e_d_rv);
      check($sformatf("row%0d busy", i),      busy,      vecs[i].e_busy);
      if (vecs[i].e_if_rv) check($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_rv)  check($sformatf("row%0d d_rdata", i),  d_rdata,  vecs[i].e_rdata);
      next_cycle();
    end
    if_req = 0; d_req = 0; d_we = 0;

    // Reset while a read of 0x0040 is in flight.
    d_req = 1; d_addr = 16'h0040;
    @(negedge clk);
    check("rst seq d_gnt", d_gnt, 1);
    next_cycle();
    d_req = 0;
    #2 reset = 1'b0;
    #1;
    check("rst mid outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 0);
    check("rst mid mem bus", {mem_addr, mem_wdata}, 0);
    check("rst mid rdata",   {if_rdata, d_rdata}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst hold c%0d", c), {if_rvalid, d_rvalid, busy, mem_en}, 0);
    end
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post rst c%0d", c), {if_rvalid, d_rvalid, busy, mem_en}, 0);
      next_cycle();
    end
    if_req = 1; if_addr = 16'h0000;
    @(negedge clk);
    check("post rst if_gnt", if_gnt, 1);
    next_cycle();
    if_req = 0;
    next_cycle();
    @(negedge clk);
    check("post rst if_rvalid", if_rvalid, 1);
    next_cycle();

    // Both requesters held continuously: grant order must follow the streak limit.
    if_req = 1; if_addr = 16'h0010;
    d_req = 1; d_we = 0; d_addr = 16'h0100;
    grants_seen = 0;
    for (int c = 0; c < 40 && grants_seen < 10; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) check("starve dual gnt", {if_gnt, d_gnt}, 2'b01);
      if (d_gnt)       begin grant_order.push_back(1'b1); grants_seen++; end
      else if (if_gnt) begin grant_order.push_back(1'b0); grants_seen++; end
      next_cycle();
    end
    if_req = 0; d_req = 0;
    check("starve grant count", grants_seen, 10);
    for (int g = 0; g < 10; g++) begin
      if (g < grant_order.size())
        check($sformatf("starve grant%0d is_d", g), grant_order[g], exp_order[g]);
    end
    repeat (3) next_cycle();

    // Latency sweep on the MEM_LAT=3 instance.
    l3_if_req = 1; l3_if_addr = 16'h0022;
    @(negedge clk);
    check("l3 if_gnt c0", l3_if_gnt, 1);
    men_count = 0;
    rv_cycle  = -1;
    next_cycle();
    l3_if_req = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (l3_mem_en) men_count++;
      if (c == 1) check("l3 mem_en c1", {l3_mem_en, l3_mem_addr}, {1'b1, 16'h0022});
      if (c == 4) check("l3 busy c4", l3_busy, 1);
      if (c == 5) check("l3 busy c5", l3_busy, 0);
      if (l3_if_rvalid) begin
        rv_cycle = c;
        check("l3 if_rdata", l3_if_rdata, 16'hFFDD);
      end
      next_cycle();
    end
    check("l3 rvalid cycle", rv_cycle, 4);
    check("l3 mem_en pulses", men_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
